// File: rtl/checkpoint_ctrl.sv
// Rename-map checkpoint allocator: hands out ring-ordered slots to branches,
// frees them on correct resolution and squashes younger slots on a mispredict.
module checkpoint_ctrl #(
  parameter int RENAME_WIDTH = 4,
  parameter int CP_NUM       = 4,
  parameter int CP_IDX_W     = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [RENAME_WIDTH-1:0] br_valid,
  input  logic                    fire,
  input  logic                    resolve_valid,
  input  logic [CP_IDX_W-1:0]     resolve_idx,
  input  logic                    resolve_mispredict,
  output logic                    check,
  output logic [CP_IDX_W-1:0]     check_idx,
  output logic [RENAME_WIDTH-1:0] check_flag,
  output logic                    cp_stall,
  output logic                    recover,
  output logic [CP_IDX_W-1:0]     recover_idx,
  output logic [CP_IDX_W:0]       cp_count,
  output logic                    multi_br_err
);

  logic [CP_IDX_W:0]       head, tail;
  logic [CP_IDX_W:0]       head_nx, tail_nx;
  logic [CP_NUM-1:0]       live, live_nx;
  logic                    recover_q;
  logic [CP_IDX_W-1:0]     recover_idx_q;

  logic                    empty, full, br_any;
  logic                    mispredict, mis_hit, good_hit, retire;
  logic [CP_IDX_W-1:0]     head_idx, tail_idx, mis_off, slot_off;
  logic [CP_IDX_W:0]       mis_pos;
  logic [RENAME_WIDTH-1:0] lowest_br;

  assign head_idx = head[CP_IDX_W-1:0];
  assign tail_idx = tail[CP_IDX_W-1:0];
  assign empty    = (head == tail);
  assign full     = (head_idx == tail_idx) && (head[CP_IDX_W] != tail[CP_IDX_W]);
  assign cp_count = tail - head;

  assign br_any       = |br_valid;
  assign lowest_br    = br_valid & (~br_valid + RENAME_WIDTH'(1));
  assign multi_br_err = |(br_valid & (br_valid - RENAME_WIDTH'(1)));

  assign mispredict = resolve_valid & resolve_mispredict;
  assign mis_hit    = mispredict & live[resolve_idx];
  assign good_hit   = resolve_valid & ~resolve_mispredict & live[resolve_idx];
  assign retire     = ~empty & ~live[head_idx];

  // Age of the mispredicted slot relative to head; adding it to head recovers
  // the full pointer (with wrap bit) that the slot occupies inside [head,tail).
  assign mis_off = resolve_idx - head_idx;
  assign mis_pos = head + {1'b0, mis_off};

  assign check      = fire & br_any & ~full & ~recover_q & ~mispredict;
  assign check_idx  = tail_idx;
  assign check_flag = check ? lowest_br : '0;
  assign cp_stall   = br_any & full;

  assign recover     = recover_q;
  assign recover_idx = recover_idx_q;

  always_comb begin
    head_nx  = head;
    tail_nx  = tail;
    live_nx  = live;
    slot_off = '0;
    if (retire)
      head_nx = head + (CP_IDX_W+1)'(1);
    if (check) begin
      live_nx[tail_idx] = 1'b1;
      tail_nx           = tail + (CP_IDX_W+1)'(1);
    end
    if (good_hit)
      live_nx[resolve_idx] = 1'b0;
    // Squash the mispredicted slot and everything allocated after it.
    if (mis_hit) begin
      tail_nx = mis_pos;
      for (int unsigned j = 0; j < CP_NUM; j++) begin
        slot_off = CP_IDX_W'(j) - head_idx;
        if (slot_off >= mis_off)
          live_nx[j] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head          <= '0;
      tail          <= '0;
      live          <= '0;
      recover_q     <= 1'b0;
      recover_idx_q <= '0;
    end else begin
      head      <= head_nx;
      tail      <= tail_nx;
      live      <= live_nx;
      recover_q <= mis_hit;
      if (mis_hit)
        recover_idx_q <= resolve_idx;
    end
  end

endmodule

// File: tb/tb_checkpoint_ctrl.sv
// Directed bench for checkpoint_ctrl: allocation, in-order retirement,
// mispredict squash, collisions, multi-branch groups, wrap and mid-run reset.
module tb_checkpoint_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] br_valid;
  logic       fire;
  logic       resolve_valid;
  logic [1:0] resolve_idx;
  logic       resolve_mispredict;
  logic       check;
  logic [1:0] check_idx;
  logic [3:0] check_flag;
  logic       cp_stall;
  logic       recover;
  logic [1:0] recover_idx;
  logic [2:0] cp_count;
  logic       multi_br_err;

  int n_cmp = 0;
  int n_bad = 0;

  checkpoint_ctrl #(.RENAME_WIDTH(4), .CP_NUM(4), .CP_IDX_W(2)) dut (
    .clock(clock), .reset(reset), .br_valid(br_valid), .fire(fire),
    .resolve_valid(resolve_valid), .resolve_idx(resolve_idx),
    .resolve_mispredict(resolve_mispredict), .check(check), .check_idx(check_idx),
    .check_flag(check_flag), .cp_stall(cp_stall), .recover(recover),
    .recover_idx(recover_idx), .cp_count(cp_count), .multi_br_err(multi_br_err)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change 1 time unit after the rising edge; outputs are sampled after settling.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [3:0] br, input logic f, input logic rv,
                       input logic [1:0] ridx, input logic rm);
    br_valid = br; fire = f; resolve_valid = rv; resolve_idx = ridx; resolve_mispredict = rm;
    #1;
  endtask

  task automatic do_reset();
    drive(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (check !== 1'b0) begin n_bad++; $display("FAIL reset_check got=%0b want=0", check); end
    n_cmp++; if (cp_count !== 3'd0) begin n_bad++; $display("FAIL reset_count got=%0d want=0", cp_count); end
    n_cmp++; if (recover !== 1'b0 || recover_idx !== 2'd0) begin n_bad++;
      $display("FAIL reset_recover got=%0b/%0d want=0/0", recover, recover_idx); end
    n_cmp++; if (cp_stall !== 1'b0 || check_flag !== 4'b0 || multi_br_err !== 1'b0) begin n_bad++;
      $display("FAIL reset_misc got stall=%0b flag=%b multi=%0b want 0/0000/0", cp_stall, check_flag, multi_br_err); end
  endtask

  task automatic test_alloc_full();
    for (int i = 0; i < 4; i++) begin
      drive(4'b0001, 1'b1, 1'b0, 2'd0, 1'b0);
      n_cmp++; if (check !== 1'b1 || check_idx !== 2'(i) || check_flag !== 4'b0001) begin n_bad++;
        $display("FAIL alloc_%0d got check=%0b idx=%0d flag=%b want 1/%0d/0001", i, check, check_idx, check_flag, i); end
      tick();
    end
    drive(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    n_cmp++; if (cp_count !== 3'd4) begin n_bad++; $display("FAIL full_count got=%0d want=4", cp_count); end
    drive(4'b0001, 1'b1, 1'b0, 2'd0, 1'b0);
    n_cmp++; if (cp_stall !== 1'b1 || check !== 1'b0) begin n_bad++;
      $display("FAIL full_stall got stall=%0b check=%0b want 1/0", cp_stall, check); end
    tick();
    drive(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    n_cmp++; if (cp_count !== 3'd4) begin n_bad++; $display("FAIL full_hold got=%0d want=4", cp_count); end
  endtask

  task automatic test_resolve_order();
    drive(4'b0000, 1'b0, 1'b1, 2'd2, 1'b0);
    tick();
    drive(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    n_cmp++; if (cp_count !== 3'd4) begin n_bad++; $display("FAIL res2_count got=%0d want=4", cp_count); end
    drive(4'b0000, 1'b0, 1'b1, 2'd0, 1'b0);
    tick();
    drive(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    n_cmp++; if (cp_count !== 3'd4) begin n_bad++; $display("FAIL res0_same_cycle got=%0d want=4", cp_count); end
    tick();
    n_cmp++; if (cp_count !== 3'd3) begin n_bad++; $display("FAIL res0_retire got=%0d want=3", cp_count); end
    tick();
    n_cmp++; if (cp_count !== 3'd3) begin n_bad++; $display("FAIL slot1_blocks got=%0d want=3", cp_count); end
    drive(4'b0000, 1'b0, 1'b1, 2'd1, 1'b0);
    tick();
    drive(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    tick();
    n_cmp++; if (cp_count !== 3'd2) begin n_bad++; $display("FAIL drain1 got=%0d want=2", cp_count); end
    tick();
    n_cmp++; if (cp_count !== 3'd1) begin n_bad++; $display("FAIL drain2 got=%0d want=1", cp_count); end
    tick();
    n_cmp++; if (cp_count !== 3'd1) begin n_bad++; $display("FAIL slot3_live got=%0d want=1", cp_count); end
  endtask

  task automatic test_mispredict();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(4'b0001, 1'b1, 1'b0, 2'd0, 1'b0);
      tick();
    end
    drive(4'b0000, 1'b0, 1'b1, 2'd1, 1'b1);
    tick();
    drive(4'b0001, 1'b1, 1'b0, 2'd0, 1'b0);
    n_cmp++; if (recover !== 1'b1 || recover_idx !== 2'd1) begin n_bad++;
      $display("FAIL mis_recover got=%0b/%0d want=1/1", recover, recover_idx); end
    n_cmp++; if (cp_count !== 3'd1) begin n_bad++; $display("FAIL mis_count got=%0d want=1", cp_count); end
    n_cmp++; if (check !== 1'b0) begin n_bad++; $display("FAIL recover_blocks_check got=%0b want=0", check); end
    tick();
    n_cmp++; if (recover !== 1'b0) begin n_bad++; $display("FAIL recover_pulse got=%0b want=0", recover); end
    n_cmp++; if (check !== 1'b1 || check_idx !== 2'd1) begin n_bad++;
      $display("FAIL mis_realloc got=%0b/%0d want=1/1", check, check_idx); end
    tick();
    drive(4'b0000, 1'b0, 1'b1, 2'd2, 1'b1);
    tick();
    drive(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    n_cmp++; if (recover !== 1'b0 || cp_count !== 3'd2) begin n_bad++;
      $display("FAIL dead_slot_mis got rec=%0b cnt=%0d want 0/2", recover, cp_count); end
  endtask

  task automatic test_mispredict_with_alloc();
    drive(4'b0001, 1'b1, 1'b1, 2'd0, 1'b1);
    n_cmp++; if (check !== 1'b0) begin n_bad++; $display("FAIL collide_check got=%0b want=0", check); end
    tick();
    drive(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    n_cmp++; if (recover !== 1'b1 || recover_idx !== 2'd0) begin n_bad++;
      $display("FAIL collide_recover got=%0b/%0d want=1/0", recover, recover_idx); end
    n_cmp++; if (cp_count !== 3'd0) begin n_bad++; $display("FAIL collide_count got=%0d want=0", cp_count); end
    tick();
    drive(4'b0001, 1'b1, 1'b0, 2'd0, 1'b0);
    n_cmp++; if (check !== 1'b1 || check_idx !== 2'd0) begin n_bad++;
      $display("FAIL collide_next got=%0b/%0d want=1/0", check, check_idx); end
    drive(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic test_multi_branch();
    drive(4'b0110, 1'b1, 1'b0, 2'd0, 1'b0);
    n_cmp++; if (multi_br_err !== 1'b1 || check_flag !== 4'b0010 || check !== 1'b1) begin n_bad++;
      $display("FAIL multi_br got err=%0b flag=%b chk=%0b want 1/0010/1", multi_br_err, check_flag, check); end
    drive(4'b1000, 1'b0, 1'b0, 2'd0, 1'b0);
    n_cmp++; if (multi_br_err !== 1'b0 || check !== 1'b0 || check_flag !== 4'b0000) begin n_bad++;
      $display("FAIL single_nofire got err=%0b chk=%0b flag=%b want 0/0/0000", multi_br_err, check, check_flag); end
    drive(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(4'b0001, 1'b1, (k > 0), 2'((k + 3) % 4), 1'b0);
      n_cmp++; if (check !== 1'b1 || check_idx !== 2'(k % 4)) begin n_bad++;
        $display("FAIL wrap_%0d got=%0b/%0d want=1/%0d", k, check, check_idx, k % 4); end
      tick();
    end
    drive(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    n_cmp++; if (cp_count !== 3'd2) begin n_bad++; $display("FAIL wrap_count got=%0d want=2", cp_count); end
    reset = 1'b1;
    drive(4'b0000, 1'b0, 1'b1, 2'd1, 1'b1);
    tick();
    reset = 1'b0;
    drive(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    n_cmp++; if (cp_count !== 3'd0 || recover !== 1'b0) begin n_bad++;
      $display("FAIL midreset got cnt=%0d rec=%0b want 0/0", cp_count, recover); end
    drive(4'b0001, 1'b1, 1'b0, 2'd0, 1'b0);
    n_cmp++; if (check !== 1'b1 || check_idx !== 2'd0) begin n_bad++;
      $display("FAIL postreset_alloc got=%0b/%0d want=1/0", check, check_idx); end
    tick();
    drive(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    br_valid = '0; fire = 1'b0; resolve_valid = 1'b0; resolve_idx = '0; resolve_mispredict = 1'b0;
    #1;
    test_reset();
    test_alloc_full();
    test_resolve_order();
    test_mispredict();
    test_mispredict_with_alloc();
    test_multi_branch();
    test_wrap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
